// File: rtl/acc8_frame_if.sv
// Operand stream in, frame result out: the two valid/ready channels of acc8_frame.
interface acc8_frame_if #(
    parameter int N_OPS = 4,
    localparam int CNT_W = $clog2(N_OPS + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_sum;
    logic             out_ovf;
    logic [CNT_W-1:0] out_cnt;

    // Upstream producer / downstream consumer side.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_cnt
    );

    // Accumulator side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_cnt
    );
endinterface

// File: rtl/acc8_frame.sv
// acc8_frame: sums N_OPS 8-bit operands per frame through one ripple adder,
// tracks carry-out as a sticky overflow flag and presents the frame result
// over a valid/ready handshake.

// 8-bit ripple-carry adder.
module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
    end

    assign cout = c[8];
endmodule

module acc8_frame #(
    parameter int N_OPS = 4,
    localparam int CNT_W = $clog2(N_OPS + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    acc8_frame_if.slave  bus
);
    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state, state_n;
    logic [7:0]       acc, acc_n;
    logic             ovf, ovf_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic [7:0] add_sum;
    logic       add_cout;

    adder8 u_add (
        .a    (acc),
        .b    (bus.in_data),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // clr blocks acceptance so an operand presented with an abort is never consumed.
    assign bus.in_ready  = (state == ACCUM) && !clr;
    assign bus.out_valid = (state == HOLD);
    // In HOLD cnt sits at N_OPS, so the running values double as the frame result.
    assign bus.out_sum   = acc;
    assign bus.out_ovf   = ovf;
    assign bus.out_cnt   = cnt;

    // State and datapath registers; reset discards any partial frame or held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            ovf   <= ovf_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: clr aborts, ACCUM adds accepted operands, HOLD waits for the consumer.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        ovf_n   = ovf;
        cnt_n   = cnt;
        if (clr) begin
            state_n = ACCUM;
            acc_n   = '0;
            ovf_n   = 1'b0;
            cnt_n   = '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc_n = add_sum;
                        ovf_n = ovf | add_cout;
                        cnt_n = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(N_OPS - 1)) state_n = HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_n = ACCUM;
                        acc_n   = '0;
                        ovf_n   = 1'b0;
                        cnt_n   = '0;
                    end
                end
                default: state_n = ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_acc8_frame.sv
// Directed bench for acc8_frame: table of frames plus hand-written clr and
// asynchronous-reset sequences.
module tb_acc8_frame;
    localparam int N_OPS = 4;

    logic clk;
    logic rst_n;
    logic clr;

    acc8_frame_if #(.N_OPS(N_OPS)) bus ();

    acc8_frame #(.N_OPS(N_OPS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0][7:0] op;
        logic [3:0][3:0] gap;   // idle cycles before each operand
        logic [3:0]      hold;  // cycles of out_ready=0 in HOLD
        logic [7:0]      sum;
        logic            ovf;
    } vec_t;

    function automatic vec_t mk(input int a, input int b, input int c, input int d,
                                input int ga, input int gb, input int gc, input int gd,
                                input int hold, input int sum, input int ovf);
        vec_t v;
        v.op[0] = 8'(a); v.op[1] = 8'(b); v.op[2] = 8'(c); v.op[3] = 8'(d);
        v.gap[0] = 4'(ga); v.gap[1] = 4'(gb); v.gap[2] = 4'(gc); v.gap[3] = 4'(gd);
        v.hold = 4'(hold);
        v.sum  = 8'(sum);
        v.ovf  = ovf[0];
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Entered and left at posedge+1; operands are accepted on the posedges.
    task automatic send_ops(input vec_t v);
        for (int k = 0; k < N_OPS; k++) begin
            for (int g = 0; g < int'(v.gap[k]); g++) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'hEE;
                @(negedge clk);
                chk("gap_cnt", int'(bus.out_cnt), k);
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = v.op[k];
            @(negedge clk);
            chk("in_ready_accum", int'(bus.in_ready), 1);
            if (k == N_OPS - 1) chk("valid_before_last", int'(bus.out_valid), 0);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic run_frame(input vec_t v);
        send_ops(v);
        @(negedge clk);
        chk("out_valid", int'(bus.out_valid), 1);
        chk("out_sum", int'(bus.out_sum), int'(v.sum));
        chk("out_ovf", int'(bus.out_ovf), int'(v.ovf));
        chk("out_cnt", int'(bus.out_cnt), N_OPS);
        chk("in_ready_hold", int'(bus.in_ready), 0);
        // Backpressure, with an operand offered that must not be taken.
        for (int h = 0; h < int'(v.hold); h++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hAA;
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_valid", int'(bus.out_valid), 1);
            chk("bp_sum", int'(bus.out_sum), int'(v.sum));
            chk("bp_in_ready", int'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("post_valid", int'(bus.out_valid), 0);
        chk("post_in_ready", int'(bus.in_ready), 1);
        chk("post_cnt", int'(bus.out_cnt), 0);
        chk("post_sum", int'(bus.out_sum), 0);
        @(posedge clk); #1;
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = mk(35, 62, 10, 16,  0, 0, 0, 0,  0, 123, 0);
        vecs[1] = mk(200, 100, 0, 0,  0, 0, 0, 0,  0, 44, 1);
        vecs[2] = mk(1, 1, 1, 1,      0, 0, 0, 0,  0, 4, 0);
        vecs[3] = mk(19, 14, 5, 7,    0, 2, 1, 0,  0, 45, 0);
        vecs[4] = mk(19, 14, 5, 7,    0, 0, 0, 0,  0, 45, 0);
        vecs[5] = mk(35, 62, 10, 16,  0, 0, 0, 0,  5, 123, 0);
        vecs[6] = mk(255, 1, 255, 1,  0, 0, 0, 0,  0, 0, 1);

        rst_n         = 1'b0;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_sum", int'(bus.out_sum), 0);
        chk("rst_ovf", int'(bus.out_ovf), 0);
        chk("rst_cnt", int'(bus.out_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk); #1;

        foreach (vecs[i]) run_frame(vecs[i]);

        // Abort after two operands; the partial frame must vanish.
        send_ops(mk(35, 62, 0, 0, 0, 0, 0, 0, 0, 0, 0) );
        // send_ops accepted all four slots above; use a fresh abort sequence instead.
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'd35; @(posedge clk); #1;
        bus.in_data = 8'd62; @(posedge clk); #1;
        clr = 1'b1;
        bus.in_data = 8'd77;
        @(negedge clk);
        chk("clr_in_ready", int'(bus.in_ready), 0);
        chk("clr_cnt_before", int'(bus.out_cnt), 2);
        chk("clr_sum_before", int'(bus.out_sum), 97);
        @(posedge clk); #1;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("clr_cnt_after", int'(bus.out_cnt), 0);
        chk("clr_sum_after", int'(bus.out_sum), 0);
        chk("clr_valid_after", int'(bus.out_valid), 0);
        @(posedge clk); #1;
        run_frame(mk(1, 2, 3, 4, 0, 0, 0, 0, 0, 10, 0));

        // clr in HOLD beats a same-cycle out_ready.
        send_ops(mk(200, 100, 0, 0, 0, 0, 0, 0, 0, 44, 1));
        clr = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("clr_hold_valid", int'(bus.out_valid), 0);
        chk("clr_hold_ovf", int'(bus.out_ovf), 0);
        chk("clr_hold_in_ready", int'(bus.in_ready), 1);
        @(posedge clk); #1;

        // Asynchronous reset mid-cycle while holding 123.
        send_ops(mk(35, 62, 10, 16, 0, 0, 0, 0, 0, 123, 0));
        @(negedge clk);
        chk("hold_before_rst", int'(bus.out_sum), 123);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(bus.out_valid), 0);
        chk("arst_sum", int'(bus.out_sum), 0);
        chk("arst_cnt", int'(bus.out_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(mk(10, 16, 19, 14, 0, 0, 0, 0, 0, 59, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/acc8_frame.md
Name: acc8_frame

Overview:
- Sequential accumulator stage that sits directly upstream of, and wraps, the 8-bit ripple adder (`adder8`).
- Accepts a stream of 8-bit operands over a valid/ready handshake and feeds each operand, with the running sum, into one `adder8` instance.
- Registers each sum and tracks carry-out overflow.
- Presents one frame result (sum of N_OPS operands) over an output valid/ready handshake to the consumer.

Parameters:
- N_OPS, 4, operands per frame; legal range 2..255.
- CNT_W, $clog2(N_OPS+1), width of the operand counter; derived, must not be overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- clr  input  1  synchronous frame abort; highest priority after reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts an operand this cycle.
- in_data  input  8  unsigned operand.
- out_valid  output  1  frame result is valid.
- out_ready  input  1  consumer takes the result this cycle.
- out_sum  output  8  frame sum modulo 256.
- out_ovf  output  1  sticky: at least one addition in the frame produced a carry-out.
- out_cnt  output  CNT_W  operands accepted in the current frame (debug/visibility).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=ACCUM; acc=0, ovf=0, cnt=0.
  - out_valid=0, out_sum=0, out_ovf=0, out_cnt=0; in_ready=1 once rst_n=1.
  - Reset mid-frame or mid-HOLD discards all partial data; no result is emitted.
- States: ACCUM, HOLD.
- ACCUM:
  - in_ready=~clr.
  - Accept when in_valid & in_ready. On that edge:
    - acc <= adder8(acc, in_data).sum
    - ovf <= ovf | cout, where cout=(acc[7]&in_data[7]) | ((acc[7]^in_data[7]) & ~sum[7])
    - cnt <= cnt+1
  - When the accepted operand is number N_OPS, the same edge moves to HOLD.
  - in_valid low: no change (gaps allowed, unlimited length).
- HOLD:
  - in_ready=0; out_valid=1.
  - out_sum=acc, out_ovf=ovf, out_cnt=N_OPS; all three held stable until handshake.
  - Handshake out_valid & out_ready: on that edge acc=0, ovf=0, cnt=0, state=ACCUM. The next operand may be accepted the cycle after the handshake; no same-cycle bypass.
- Latency: out_valid rises the cycle after the edge that accepts the last operand.
- Throughput: 1 operand per cycle in ACCUM. Frame period is at least N_OPS+1 cycles.
- Outputs when out_valid=0: out_sum=acc, out_ovf=ovf, out_cnt=cnt (running values, not valid data).
- clr=1 in either state:
  - Next edge: acc=0, ovf=0, cnt=0, state=ACCUM.
  - An operand presented with clr is not accepted (in_ready=0).
  - clr in HOLD drops the result even if out_ready=1 the same cycle. The consumer must ignore that beat: out_valid & clr is not a transfer.
- Wrap-around:
  - Sum is modulo 256; carries beyond bit 7 are reflected only in out_ovf.
  - cnt never exceeds N_OPS.
- Handshake rules: upstream holds in_data stable while in_valid=1 and in_ready=0. The block never drops out_valid without a handshake, clr, or reset.

Test Plan:
- Frame of 35,62,10,16, back-to-back, out_ready=1:
  - out_valid one cycle after the 4th accept.
  - out_sum=123, out_ovf=0, out_cnt=4.
- Frame of 200,100,0,0:
  - out_sum=44, out_ovf=1.
  - Next frame 1,1,1,1 gives out_sum=4, out_ovf=0, confirming the sticky flag clears between frames.
- Backpressure: complete a frame with out_ready=0 for 5 cycles:
  - out_valid=1 and out_sum held for all 5 cycles; in_ready=0 throughout.
  - Result accepted when out_ready rises; in_ready=1 the following cycle.
- Gapped input 19,–,–,14,–,5,7 (in_valid low on the gaps): out_sum=45, same result as with no gaps.
- clr after 2 operands (35,62), then 1,2,3,4: out_sum=10, out_cnt=4; no result emitted for the aborted partial frame.
- rst_n pulsed low asynchronously, mid-cycle, while in HOLD with out_sum=123:
  - Outputs go to 0 immediately, before the next clock edge.
  - After release, frame 10,16,19,14 gives out_sum=59.
